ld_st_sequencer: RTL and testbench

- Control-step FSM that drives the datapath control inputs for instruction fetch plus the memory-class instructions ld, ldi and st.
- Replaces hand-driven control waveforms with a fixed, cycle-exact T-step sequence.
- Sits beside datapath: it drives the datapath control inputs and reads only the IR opcode field back.

---
 rtl/ld_st_sequencer_pkg.sv | 56 +++++
 rtl/ld_st_sequencer_if.sv | 28 ++
 rtl/ld_st_sequencer.sv | 114 +++++++++++
 tb/tb_ld_st_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_st_sequencer_pkg.sv
// Shared opcode, bus-source and state definitions for the load/store control sequencer.
package ld_st_sequencer_pkg;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [4:0] BUS_NONE = 5'b00000;
  localparam logic [4:0] BUS_ZLO  = 5'b10011;
  localparam logic [4:0] BUS_PC   = 5'b10100;
  localparam logic [4:0] BUS_MDR  = 5'b10101;
  localparam logic [4:0] BUS_C    = 5'b11000;

  // Illegal-opcode completion gets its own DONE state so that illegal stays a pure state decode.
  localparam logic [4:0] S_IDLE     = 5'd0;
  localparam logic [4:0] S_F0       = 5'd1;
  localparam logic [4:0] S_F1       = 5'd2;
  localparam logic [4:0] S_F2       = 5'd3;
  localparam logic [4:0] S_F3       = 5'd4;
  localparam logic [4:0] S_F4       = 5'd5;
  localparam logic [4:0] S_A0       = 5'd6;
  localparam logic [4:0] S_A1       = 5'd7;
  localparam logic [4:0] S_A2       = 5'd8;
  localparam logic [4:0] S_R0       = 5'd9;
  localparam logic [4:0] S_R1       = 5'd10;
  localparam logic [4:0] S_WB       = 5'd11;
  localparam logic [4:0] S_LDI_WB   = 5'd12;
  localparam logic [4:0] S_SM       = 5'd13;
  localparam logic [4:0] S_SW       = 5'd14;
  localparam logic [4:0] S_DONE     = 5'd15;
  localparam logic [4:0] S_DONE_ILL = 5'd16;

  typedef struct packed {
    logic       inc_pc;
    logic       e_ir;
    logic       e_y;
    logic       e_z;
    logic       e_mdr;
    logic       e_mar;
    logic       ram_read;
    logic       ram_write;
    logic       mdr_read;
    logic       gra;
    logic       grb;
    logic       e_rin;
    logic       e_rout;
    logic       ba_out;
    logic       imm_sel;
    logic [3:0] alu_op;
    logic [4:0] bus_sel;
    logic       busy;
    logic       done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ld_st_sequencer_if.sv
// Datapath control bundle: the sequencer is the master, the datapath the slave.
interface ld_st_sequencer_if;
  import ld_st_sequencer_pkg::*;

  logic       start;
  logic       halt;
  logic [4:0] ir_opcode;
  logic       incPC, e_IR, e_Y, e_Z, e_MDR, e_MAR, ram_read, ram_write, MDR_read;
  logic       Gra, Grb, e_Rin, e_Rout, BAout, imm_sel;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;
  logic       busy, done, illegal;

  modport master (
    input  start, halt, ir_opcode,
    output incPC, e_IR, e_Y, e_Z, e_MDR, e_MAR, ram_read, ram_write, MDR_read,
    output Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect,
    output busy, done, illegal
  );

  modport slave (
    output start, halt, ir_opcode,
    input  incPC, e_IR, e_Y, e_Z, e_MDR, e_MAR, ram_read, ram_write, MDR_read,
    input  Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, ALU_op, BusDataSelect,
    input  busy, done, illegal
  );

endinterface

// File: rtl/ld_st_sequencer.sv
// T-step control sequencer for instruction fetch plus ld / ldi / st.
//
// state      | meaning
// IDLE       | waiting for start, all controls low
// F0..F4     | fetch: PC increment, MAR<-PC, two-cycle RAM read, IR<-MDR
// A0, A1     | effective address: Y<-Rb (0 for R0), Z<-Y+C
// A2         | MAR<-Z (ld and st only)
// R0, R1     | ld memory read into MDR
// WB         | ld write-back Ra<-MDR
// LDI_WB     | ldi write-back Ra<-Z
// SM, SW     | st: MDR<-Ra from the bus, then RAM write
// DONE       | one-cycle completion pulse
// DONE_ILL   | completion pulse with illegal for an unsupported opcode
module ld_st_sequencer
  import ld_st_sequencer_pkg::*;
#(
  parameter bit         AUTO_RUN = 1'b0,
  parameter logic [3:0] ALU_ADD  = 4'b0011
) (
  input  logic              clock,
  input  logic              clear,
  ld_st_sequencer_if.master sif
);

  logic [4:0] r_state;
  logic [4:0] w_next;
  ctrl_t      w_ctl;

  // State register; clear forces IDLE at once, even mid-instruction.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: fixed step order, opcode branches at A1 and A2 exits.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = sif.start ? S_F0 : S_IDLE;
      S_F0:     w_next = S_F1;
      S_F1:     w_next = S_F2;
      S_F2:     w_next = S_F3;
      S_F3:     w_next = S_F4;
      S_F4:     w_next = S_A0;
      S_A0:     w_next = S_A1;
      S_A1: begin
        if (sif.ir_opcode == OP_LD || sif.ir_opcode == OP_ST) w_next = S_A2;
        else if (sif.ir_opcode == OP_LDI)                     w_next = S_LDI_WB;
        else                                                  w_next = S_DONE_ILL;
      end
      S_A2:     w_next = (sif.ir_opcode == OP_ST) ? S_SM : S_R0;
      S_R0:     w_next = S_R1;
      S_R1:     w_next = S_WB;
      S_WB:     w_next = S_DONE;
      S_LDI_WB: w_next = S_DONE;
      S_SM:     w_next = S_SW;
      S_SW:     w_next = S_DONE;
      S_DONE, S_DONE_ILL:
                w_next = (AUTO_RUN && !sif.halt) ? S_F0 : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore output decode from the state register alone.
  always_comb begin
    w_ctl      = '0;
    w_ctl.busy = (r_state != S_IDLE);
    case (r_state)
      S_F0:       w_ctl.inc_pc = 1'b1;
      S_F1:       begin w_ctl.bus_sel = BUS_PC; w_ctl.e_mar = 1'b1; end
      S_F2, S_R0: begin w_ctl.ram_read = 1'b1; w_ctl.mdr_read = 1'b1; end
      S_F3, S_R1: begin w_ctl.ram_read = 1'b1; w_ctl.mdr_read = 1'b1; w_ctl.e_mdr = 1'b1; end
      S_F4:       begin w_ctl.bus_sel = BUS_MDR; w_ctl.e_ir = 1'b1; end
      S_A0:       begin w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.e_y = 1'b1; end
      S_A1: begin
        w_ctl.bus_sel = BUS_C;
        w_ctl.imm_sel = 1'b1;
        w_ctl.alu_op  = ALU_ADD;
        w_ctl.e_z     = 1'b1;
      end
      S_A2:       begin w_ctl.bus_sel = BUS_ZLO; w_ctl.e_mar = 1'b1; end
      S_WB:       begin w_ctl.bus_sel = BUS_MDR; w_ctl.gra = 1'b1; w_ctl.e_rin = 1'b1; end
      S_LDI_WB:   begin w_ctl.bus_sel = BUS_ZLO; w_ctl.gra = 1'b1; w_ctl.e_rin = 1'b1; end
      // MDR_read stays low so MDR captures Ra from the bus instead of RAM.
      S_SM:       begin w_ctl.gra = 1'b1; w_ctl.e_rout = 1'b1; w_ctl.e_mdr = 1'b1; end
      S_SW:       w_ctl.ram_write = 1'b1;
      S_DONE:     w_ctl.done = 1'b1;
      S_DONE_ILL: begin w_ctl.done = 1'b1; w_ctl.illegal = 1'b1; end
      default:    ;
    endcase
  end

  assign sif.incPC         = w_ctl.inc_pc;
  assign sif.e_IR          = w_ctl.e_ir;
  assign sif.e_Y           = w_ctl.e_y;
  assign sif.e_Z           = w_ctl.e_z;
  assign sif.e_MDR         = w_ctl.e_mdr;
  assign sif.e_MAR         = w_ctl.e_mar;
  assign sif.ram_read      = w_ctl.ram_read;
  assign sif.ram_write     = w_ctl.ram_write;
  assign sif.MDR_read      = w_ctl.mdr_read;
  assign sif.Gra           = w_ctl.gra;
  assign sif.Grb           = w_ctl.grb;
  assign sif.e_Rin         = w_ctl.e_rin;
  assign sif.e_Rout        = w_ctl.e_rout;
  assign sif.BAout         = w_ctl.ba_out;
  assign sif.imm_sel       = w_ctl.imm_sel;
  assign sif.ALU_op        = w_ctl.alu_op;
  assign sif.BusDataSelect = w_ctl.bus_sel;
  assign sif.busy          = w_ctl.busy;
  assign sif.done          = w_ctl.done;
  assign sif.illegal       = w_ctl.illegal;

endmodule

// File: tb/tb_ld_st_sequencer.sv
// Bench for ld_st_sequencer: a cycle-stamped expected-control map built from
// per-instruction step lists, plus a small datapath model driven by the DUT.
module tb_ld_st_sequencer;
  import ld_st_sequencer_pkg::*;

  logic clock;
  logic clear;
  int   cyc;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  ld_st_sequencer_if dif ();
  ld_st_sequencer_if aif ();

  ld_st_sequencer #(.AUTO_RUN(1'b0), .ALU_ADD(4'b0011)) u_dut (
    .clock(clock), .clear(clear), .sif(dif.master));
  ld_st_sequencer #(.AUTO_RUN(1'b1), .ALU_ADD(4'b0011)) u_dut_ar (
    .clock(clock), .clear(clear), .sif(aif.master));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Expected control words keyed by absolute cycle; absent key means idle.
  logic [26:0] exp_m[int];
  logic [26:0] exp_ar[int];

  logic [26:0] w_a, w_ar;
  assign w_a  = {dif.incPC, dif.e_IR, dif.e_Y, dif.e_Z, dif.e_MDR, dif.e_MAR, dif.ram_read,
                 dif.ram_write, dif.MDR_read, dif.Gra, dif.Grb, dif.e_Rin, dif.e_Rout,
                 dif.BAout, dif.imm_sel, dif.ALU_op, dif.BusDataSelect, dif.busy,
                 dif.done, dif.illegal};
  assign w_ar = {aif.incPC, aif.e_IR, aif.e_Y, aif.e_Z, aif.e_MDR, aif.e_MAR, aif.ram_read,
                 aif.ram_write, aif.MDR_read, aif.Gra, aif.Grb, aif.e_Rin, aif.e_Rout,
                 aif.BAout, aif.imm_sel, aif.ALU_op, aif.BusDataSelect, aif.busy,
                 aif.done, aif.illegal};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Control word for one named step of the published step list.
  function automatic logic [26:0] step_word(input string s);
    logic ip, eir, ey, ez, emdr, emar, rr, rw, mr, gra, grb, erin, erout, ba, imm, dn, il;
    logic [3:0] alu;
    logic [4:0] bsel;
    {ip, eir, ey, ez, emdr, emar, rr, rw, mr, gra, grb, erin, erout, ba, imm, dn, il} = '0;
    alu  = 4'h0;
    bsel = BUS_NONE;
    case (s)
      "F0":     ip = 1;
      "F1":     begin bsel = BUS_PC; emar = 1; end
      "F2":     begin rr = 1; mr = 1; end
      "F3":     begin rr = 1; mr = 1; emdr = 1; end
      "F4":     begin bsel = BUS_MDR; eir = 1; end
      "A0":     begin grb = 1; ba = 1; ey = 1; end
      "A1":     begin bsel = BUS_C; imm = 1; alu = 4'b0011; ez = 1; end
      "A2":     begin bsel = BUS_ZLO; emar = 1; end
      "R0":     begin rr = 1; mr = 1; end
      "R1":     begin rr = 1; mr = 1; emdr = 1; end
      "WB":     begin bsel = BUS_MDR; gra = 1; erin = 1; end
      "LDI_WB": begin bsel = BUS_ZLO; gra = 1; erin = 1; end
      "SM":     begin gra = 1; erout = 1; emdr = 1; end
      "SW":     rw = 1;
      "DONE":   dn = 1;
      "ILL":    begin dn = 1; il = 1; end
      default:  ;
    endcase
    return {ip, eir, ey, ez, emdr, emar, rr, rw, mr, gra, grb, erin, erout, ba, imm,
            alu, bsel, 1'b1, dn, il};
  endfunction

  // Fill the expectation map: step k of the instruction lands at cycle base+k.
  task automatic sched(input int base, input logic [4:0] op, input bit ar);
    string s[$];
    s = '{"F0", "F1", "F2", "F3", "F4", "A0", "A1"};
    if (op == OP_LD) begin
      s.push_back("A2"); s.push_back("R0"); s.push_back("R1"); s.push_back("WB"); s.push_back("DONE");
    end else if (op == OP_ST) begin
      s.push_back("A2"); s.push_back("SM"); s.push_back("SW"); s.push_back("DONE");
    end else if (op == OP_LDI) begin
      s.push_back("LDI_WB"); s.push_back("DONE");
    end else begin
      s.push_back("ILL");
    end
    foreach (s[i]) begin
      if (ar) exp_ar[base + 1 + i] = step_word(s[i]);
      else    exp_m[base + 1 + i]  = step_word(s[i]);
    end
  endtask

  // Per-cycle compare of both instances against the expectation maps.
  always @(negedge clock) begin
    if (chk_en) begin
      check("ctl", {5'h0, w_a}, {5'h0, exp_m.exists(cyc) ? exp_m[cyc] : 27'h0});
      check("ctl_ar", {5'h0, w_ar}, {5'h0, exp_ar.exists(cyc) ? exp_ar[cyc] : 27'h0});
      check("rd_wr_excl", {31'h0, dif.ram_read & dif.ram_write}, 32'h0);
      check("ill_wo_done", {31'h0, dif.illegal & ~dif.done}, 32'h0);
    end
  end

  // Minimal datapath: bus, PC, MAR, MDR, IR, Y, Z, register file, RAM.
  logic [31:0] R[16];
  logic [31:0] mem[256];
  logic [31:0] pc_m, mar, mdr, ir, y, z;
  int          wr_cnt;
  bit          dp_init;
  logic        pre_valid;
  int          pre_kind;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  assign dif.ir_opcode = ir[31:27];

  always @(posedge clock) begin : dp
    logic [31:0] b;
    logic [3:0]  ra, rb;
    if (!dp_init) begin
      for (int i = 0; i < 16; i++) R[i] = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      {pc_m, mar, mdr, ir, y, z} = '0;
      dp_init = 1'b1;
    end
    if (pre_valid) begin
      case (pre_kind)
        0:       R[pre_addr[3:0]] = pre_data;
        1:       mem[pre_addr]    = pre_data;
        default: pc_m             = pre_data;
      endcase
    end
    ra = ir[26:23];
    rb = ir[22:19];
    case (dif.BusDataSelect)
      BUS_PC:  b = pc_m;
      BUS_MDR: b = mdr;
      BUS_ZLO: b = z;
      BUS_C:   b = dif.imm_sel ? {{13{ir[18]}}, ir[18:0]} : 32'h0;
      default: b = 32'h0;
    endcase
    if (dif.Gra && dif.e_Rout) b = R[ra];
    if (dif.Grb && dif.BAout)  b = (rb == 4'd0) ? 32'h0 : R[rb];
    if (dif.ram_write) mem[mar[7:0]] = mdr;
    if (dif.e_MDR) mdr = dif.MDR_read ? (dif.ram_read ? mem[mar[7:0]] : 32'hDEAD0000) : b;
    if (dif.e_MAR) mar = b;
    if (dif.e_IR)  ir  = b;
    if (dif.e_Y)   y   = b;
    if (dif.e_Z)   z   = (dif.ALU_op == 4'b0011) ? y + b : 32'hBAD0BAD0;
    if (dif.e_Rin && dif.Gra) begin R[ra] = b; wr_cnt++; end
    if (dif.incPC) pc_m = pc_m + 32'd1;
  end

  task automatic poke(input int kind, input logic [7:0] addr, input logic [31:0] data);
    pre_kind  = kind;
    pre_addr  = addr;
    pre_data  = data;
    pre_valid = 1'b1;
    @(posedge clock); #1;
    pre_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  // Load PC and the instruction at PC+1, pulse start, wait (bounded) for done.
  task automatic run_instr(input string tag, input logic [31:0] instr, input int exp_done);
    int base, got;
    poke(2, 8'h0, 32'h0);
    poke(1, 8'h1, instr);
    base = cyc;
    sched(base, instr[31:27], 1'b0);
    dif.start = 1'b1;
    @(posedge clock); #1;
    dif.start = 1'b0;
    got = -1;
    for (int i = 1; i <= 40 && got < 0; i++) begin
      @(negedge clock);
      if (dif.done) got = cyc - base;
    end
    check({tag, "_done_cycle"}, got, exp_done);
    @(posedge clock); #1;
  endtask

  initial begin : stim
    int base;
    n_tests = 0; n_fail = 0; chk_en = 0; wr_cnt = 0;
    pre_valid = 0; pre_kind = 0; pre_addr = 0; pre_data = 0;
    clear = 1'b0;
    dif.start = 0; dif.halt = 0;
    aif.start = 0; aif.halt = 0; aif.ir_opcode = OP_LD;
    #1;
    check("reset_ctl", {5'h0, w_a}, 32'h0);
    check("reset_busy", {31'h0, dif.busy}, 32'h0);
    #21 clear = 1'b1;
    @(posedge clock); #1;
    chk_en = 1;

    // ld R2, 0x50(R0) with mem[0x50]=0x1234
    poke(1, 8'h50, 32'h00001234);
    poke(0, 8'h2, 32'h0);
    run_instr("ld", enc(OP_LD, 4'd2, 4'd0, 19'h50), 12);
    check("ld_R2", R[2], 32'h00001234);
    check("ld_PC", pc_m, 32'h1);
    check("ld_busy_after", {31'h0, dif.busy}, 32'h0);

    // st R3, 0x5(R1)
    poke(0, 8'h3, 32'h0000ABCD);
    poke(0, 8'h1, 32'h00000010);
    run_instr("st", enc(OP_ST, 4'd3, 4'd1, 19'h5), 11);
    check("st_mem15", mem[8'h15], 32'h0000ABCD);

    // ldi R4, 0x7(R0); R0 holds junk to show BAout forces zero
    poke(0, 8'h0, 32'h00000099);
    run_instr("ldi", enc(OP_LDI, 4'd4, 4'd0, 19'h7), 9);
    check("ldi_R4", R[4], 32'h7);

    // unsupported opcode: no register write, back to IDLE
    poke(0, 8'h5, 32'h00005555);
    base = wr_cnt;
    run_instr("ill", enc(5'b01111, 4'd5, 4'd0, 19'h3), 8);
    check("ill_R5", R[5], 32'h00005555);
    check("ill_no_wr", wr_cnt, base);
    check("ill_idle", {31'h0, dif.busy}, 32'h0);

    // clear dropped mid-ld during R0
    poke(2, 8'h0, 32'h0);
    poke(1, 8'h1, enc(OP_LD, 4'd6, 4'd0, 19'h50));
    poke(0, 8'h6, 32'h0);
    base = cyc;
    sched(base, OP_LD, 1'b0);
    dif.start = 1'b1;
    @(posedge clock); #1;
    dif.start = 1'b0;
    for (int i = 0; i < 20 && cyc < base + 9; i++) @(posedge clock);
    #2;
    check("rst_in_R0", {31'h0, dif.ram_read}, 32'h1);
    clear = 1'b0;
    for (int k = base + 9; k <= base + 12; k++) exp_m.delete(k);
    #1;
    check("rst_ctl_zero", {5'h0, w_a}, 32'h0);
    check("rst_busy", {31'h0, dif.busy}, 32'h0);
    dif.start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    dif.start = 1'b0;
    check("rst_start_ignored", {31'h0, dif.busy}, 32'h0);
    #2 clear = 1'b1;
    @(posedge clock); #1;
    check("rst_R6_untouched", R[6], 32'h0);
    run_instr("ld2", enc(OP_LD, 4'd6, 4'd0, 19'h50), 12);
    check("ld2_R6", R[6], 32'h00001234);

    // AUTO_RUN: two back-to-back ld, halt raised during the second
    base = cyc;
    sched(base, OP_LD, 1'b1);
    sched(base + 12, OP_LD, 1'b1);
    aif.start = 1'b1;
    @(posedge clock); #1;
    aif.start = 1'b0;
    for (int i = 0; i < 30 && cyc < base + 13; i++) @(negedge clock);
    check("ar_F0_again", {31'h0, aif.incPC}, 32'h1);
    aif.halt = 1'b1;
    for (int i = 0; i < 30 && cyc < base + 26; i++) @(negedge clock);
    check("ar_halt_idle", {31'h0, aif.busy}, 32'h0);
    aif.halt = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
